coin_acceptor: RTL and testbench
================================

// Module: coin_acceptor
// PURPOSE
//  Payment front-end directly upstream of the washing-machine controller. Debounces the raw
//  coin-slot pulse, accumulates credit by denomination, and holds the controller's coin_in
//  high once the price for a single or double wash is met. It returns change, refunds on
//  cancel or timeout, and rejects coins inserted while a wash is running.
// PARAMETERS
//  DEBOUNCE_CYCLES  4      cycles coin_raw must be stable before the filtered level changes
//  CREDIT_W         8      width of credit, refund_amt and price values
//  PRICE_SINGLE     10     credit units for a single wash
//  PRICE_DOUBLE     15     credit units for a double wash
//  COLLECT_TIMEOUT  255    idle cycles in COLLECT (no coin event) before full refund
//  ACCEPT_TIMEOUT   16     cycles in ARMED waiting for wash_done==0 before refund of price
// PORTS
//  clk             in   1         system clock, rising edge
//  rst             in   1         synchronous, active-high reset
//  coin_raw        in   1         raw coin-slot sensor; may bounce
//  coin_value      in   2         denomination, valid with coin_raw: 00=1 01=2 10=5 11=10 units
//  double_wash_req in   1         user selects double wash; level
//  cancel          in   1         user cancel/refund request; level, acts on first cycle seen
//  wash_done       in   1         from controller: 1 = idle/finished, 0 = wash running
//  coin_in         out  1         to controller: payment complete, start request
//  double_wash     out  1         to controller: double-wash option, latched at arm time
//  credit          out  CREDIT_W  current accumulated credit
//  refund_valid    out  1         one-cycle pulse: dispense refund_amt
//  refund_amt      out  CREDIT_W  refund/change amount; valid only with refund_valid
//  coin_reject     out  1         one-cycle pulse: coin arrived while ARMED/BUSY, diverted
// BEHAVIOUR
//  - Reset: state=IDLE; credit=0; coin_in=0; double_wash=0; refund_valid=0; refund_amt=0;
//    coin_reject=0; debouncer filtered level=0 and counters cleared.
//  - Debounce: the filtered level changes after DEBOUNCE_CYCLES consecutive samples differ
//    from it. A coin event is a 0->1 edge of the filtered level. coin_value is sampled in
//    the event cycle. Credit updates 1 cycle after the event (registered).
//  - Add: credit <= min(credit + value, 2^CREDIT_W-1). Saturating, never wraps.
//  - price = double_wash_req ? PRICE_DOUBLE : PRICE_SINGLE, evaluated combinationally each cycle.
//  - FSM:
//    IDLE:    coin event -> COLLECT; credit=value.
//    COLLECT: coin event adds value and resets the idle timer.
//             cancel -> REFUND of credit plus any same-cycle coin; cancel wins.
//             Idle timer reaches COLLECT_TIMEOUT -> REFUND of full credit.
//             Registered credit>=price and wash_done==1 -> ARMED. On that same transition:
//             double_wash<=double_wash_req; refund_valid=1 with refund_amt=credit-price if
//             nonzero; credit<=0.
//             credit>=price while wash_done==0 -> stay in COLLECT.
//    ARMED:   coin_in=1, held. wash_done==0 -> BUSY; coin_in=0 from the next cycle.
//             ACCEPT_TIMEOUT cycles without wash_done==0 -> REFUND of the price paid.
//             cancel is ignored.
//    BUSY:    coin_in=0; double_wash held. wash_done==1 -> IDLE and double_wash<=0.
//    REFUND:  single cycle; refund_valid=1, refund_amt=amount; credit<=0; -> IDLE.
//  - A coin event in ARMED or BUSY gives coin_reject=1 for 1 cycle; credit is unchanged.
//  - Change is never lost: at most one refund_valid pulse per cycle by construction,
//    because no two refund sources can coincide.
//  - rst mid-operation discards credit without a refund pulse and forces all outputs to
//    reset values on the next edge.
// STRUCTURE
//  - Shared package coin_pkg: state enum (IDLE, COLLECT, ARMED, BUSY, REFUND; 3-bit encoding),
//    denomination lookup constants COIN_VAL_0..3 = 1, 2, 5, 10.
//  - Sub-module coin_debounce (clk, rst, raw, level, rise_pulse), parameterised by
//    DEBOUNCE_CYCLES.
//  - Top level holds the FSM, the saturating credit adder and two timeout counters
//    (clog2 of each timeout).
// TESTING
//  1 Reset 3 cycles with coin_raw=1 -> all outputs 0, credit=0, no coin event after release.
//  2 Bouncy coin_raw (toggle every cycle for 6 cycles, then stable 1 for 4) -> exactly one
//    event; credit=10 with coin_value=11.
//  3 Coins 5,5 with double_wash_req=0 and wash_done=1 -> ARMED, coin_in=1, no refund; drop
//    wash_done -> coin_in=0 next cycle.
//  4 Coins 10,10 with double_wash_req=1 -> refund_valid pulse with refund_amt=5;
//    double_wash=1 until wash_done returns 1.
//  5 Coin 2, then cancel asserted together with coin event value 5 -> refund_amt=7, state IDLE.
//  6 Coin 1 and wait 255 cycles -> refund_amt=1. Coin inserted in BUSY -> coin_reject pulse,
//    credit=0.

Source files
------------

// File: rtl/coin_pkg.sv
// Shared types and denomination constants for the coin acceptor front-end.
package coin_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        ARMED   = 3'd2,
        BUSY    = 3'd3,
        REFUND  = 3'd4
    } coin_state_t;

    localparam int COIN_VAL_0 = 1;
    localparam int COIN_VAL_1 = 2;
    localparam int COIN_VAL_2 = 5;
    localparam int COIN_VAL_3 = 10;

    function automatic logic [3:0] coin_lut(input logic [1:0] code);
        logic [3:0] val;
        case (code)
            2'b00:   val = 4'(COIN_VAL_0);
            2'b01:   val = 4'(COIN_VAL_1);
            2'b10:   val = 4'(COIN_VAL_2);
            default: val = 4'(COIN_VAL_3);
        endcase
        return val;
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// Debounces the coin-slot sensor and flags the rising edge of the filtered level
// as a one-cycle pulse, aligned with the first cycle the filtered level reads 1.
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        if (raw != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = raw;
                rise_d  = raw;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level      = level_q;
    assign rise_pulse = rise_q;

endmodule

// File: rtl/coin_acceptor.sv
// Payment front-end for the washing-machine controller: credit accumulation,
// arming of the start request, change/refund dispensing and coin rejection.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CREDIT_W        = 8,
    parameter int PRICE_SINGLE    = 10,
    parameter int PRICE_DOUBLE    = 15,
    parameter int COLLECT_TIMEOUT = 255,
    parameter int ACCEPT_TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_raw,
    input  logic [1:0]          coin_value,
    input  logic                double_wash_req,
    input  logic                cancel,
    input  logic                wash_done,
    output logic                coin_in,
    output logic                double_wash,
    output logic [CREDIT_W-1:0] credit,
    output logic                refund_valid,
    output logic [CREDIT_W-1:0] refund_amt,
    output logic                coin_reject
);

    localparam int CT_W = (COLLECT_TIMEOUT > 1) ? $clog2(COLLECT_TIMEOUT) : 1;
    localparam int AT_W = (ACCEPT_TIMEOUT > 1) ? $clog2(ACCEPT_TIMEOUT) : 1;

    function automatic logic [CREDIT_W-1:0] sat_add(input logic [CREDIT_W-1:0] a,
                                                    input logic [CREDIT_W-1:0] b);
        logic [CREDIT_W:0] full;
        full = {1'b0, a} + {1'b0, b};
        return full[CREDIT_W] ? {CREDIT_W{1'b1}} : full[CREDIT_W-1:0];
    endfunction

    coin_state_t         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] paid_q, paid_d;
    logic [CREDIT_W-1:0] pend_q, pend_d;
    logic [CREDIT_W-1:0] refund_amt_q, refund_amt_d;
    logic [CT_W-1:0]     ctmr_q, ctmr_d;
    logic [AT_W-1:0]     atmr_q, atmr_d;
    logic                dbl_q, dbl_d;
    logic                refund_valid_q, refund_valid_d;
    logic                coin_reject_q, coin_reject_d;

    logic                coin_level, coin_rise, coin_event;
    logic [CREDIT_W-1:0] coin_amt, price, sum, change;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .raw        (coin_raw),
        .level      (coin_level),
        .rise_pulse (coin_rise)
    );

    assign coin_event = coin_rise & coin_level;
    assign coin_amt   = CREDIT_W'(coin_lut(coin_value));
    assign price      = double_wash_req ? CREDIT_W'(PRICE_DOUBLE) : CREDIT_W'(PRICE_SINGLE);

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        paid_d         = paid_q;
        pend_d         = pend_q;
        ctmr_d         = ctmr_q;
        atmr_d         = '0;
        dbl_d          = dbl_q;
        refund_valid_d = 1'b0;
        refund_amt_d   = '0;
        coin_reject_d  = 1'b0;
        sum            = coin_event ? sat_add(credit_q, coin_amt) : credit_q;
        change         = sum - price;
        case (state_q)
            IDLE: begin
                ctmr_d = '0;
                if (coin_event) begin
                    state_d  = COLLECT;
                    credit_d = coin_amt;
                end
            end
            COLLECT: begin
                // A coin landing on the arming cycle is folded into the change.
                if (cancel) begin
                    state_d = REFUND;
                    pend_d  = sum;
                end else if (credit_q >= price && wash_done) begin
                    state_d  = ARMED;
                    paid_d   = price;
                    dbl_d    = double_wash_req;
                    credit_d = '0;
                    if (change != '0) begin
                        refund_valid_d = 1'b1;
                        refund_amt_d   = change;
                    end
                end else if (coin_event) begin
                    credit_d = sum;
                    ctmr_d   = '0;
                end else if (ctmr_q == CT_W'(COLLECT_TIMEOUT - 1)) begin
                    state_d = REFUND;
                    pend_d  = credit_q;
                end else begin
                    ctmr_d = ctmr_q + 1'b1;
                end
            end
            ARMED: begin
                coin_reject_d = coin_event;
                if (!wash_done) begin
                    state_d = BUSY;
                end else if (atmr_q == AT_W'(ACCEPT_TIMEOUT - 1)) begin
                    state_d = REFUND;
                    pend_d  = paid_q;
                    dbl_d   = 1'b0;
                end else begin
                    atmr_d = atmr_q + 1'b1;
                end
            end
            BUSY: begin
                coin_reject_d = coin_event;
                if (wash_done) begin
                    state_d = IDLE;
                    dbl_d   = 1'b0;
                end
            end
            REFUND: begin
                refund_valid_d = 1'b1;
                refund_amt_d   = pend_q;
                credit_d       = '0;
                ctmr_d         = '0;
                if (coin_event) begin
                    state_d  = COLLECT;
                    credit_d = coin_amt;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            paid_q         <= '0;
            pend_q         <= '0;
            ctmr_q         <= '0;
            atmr_q         <= '0;
            dbl_q          <= 1'b0;
            refund_valid_q <= 1'b0;
            refund_amt_q   <= '0;
            coin_reject_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            paid_q         <= paid_d;
            pend_q         <= pend_d;
            ctmr_q         <= ctmr_d;
            atmr_q         <= atmr_d;
            dbl_q          <= dbl_d;
            refund_valid_q <= refund_valid_d;
            refund_amt_q   <= refund_amt_d;
            coin_reject_q  <= coin_reject_d;
        end
    end

    assign coin_in      = (state_q == ARMED);
    assign double_wash  = dbl_q;
    assign credit       = credit_q;
    assign refund_valid = refund_valid_q;
    assign refund_amt   = refund_amt_q;
    assign coin_reject  = coin_reject_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: denomination table plus directed
// sequences, with refunds checked against a scoreboard queue.
module tb_coin_acceptor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_raw = 1'b0;
    logic [1:0] coin_value = 2'b00;
    logic       double_wash_req = 1'b0;
    logic       cancel = 1'b0;
    logic       wash_done = 1'b1;
    logic       coin_in, double_wash, refund_valid, coin_reject;
    logic [7:0] credit, refund_amt;

    int n_cmp = 0;
    int n_fail = 0;
    int rej_cnt = 0;
    int sb[$];

    typedef struct {
        logic [1:0] code;
        int         exp_credit;
    } vec_t;

    vec_t vecs[4];

    coin_acceptor dut (
        .clk             (clk),
        .rst             (rst),
        .coin_raw        (coin_raw),
        .coin_value      (coin_value),
        .double_wash_req (double_wash_req),
        .cancel          (cancel),
        .wash_done       (wash_done),
        .coin_in         (coin_in),
        .double_wash     (double_wash),
        .credit          (credit),
        .refund_valid    (refund_valid),
        .refund_amt      (refund_amt),
        .coin_reject     (coin_reject)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic insert_coin(input logic [1:0] code);
        coin_value = code;
        coin_raw   = 1'b1;
        cycle(6);
        coin_raw   = 1'b0;
        cycle(6);
    endtask

    task automatic pulse_cancel();
        cancel = 1'b1;
        cycle(1);
        cancel = 1'b0;
    endtask

    task automatic wait_sb(input string nm, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) break;
            cycle(1);
        end
        check({nm, "_pending_refunds"}, sb.size(), 0);
    endtask

    // Refund scoreboard and reject counter, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (refund_valid) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_refund: got refund_amt=%0d, expected no refund", refund_amt);
                end else begin
                    int exp_amt;
                    exp_amt = sb.pop_front();
                    if (int'(refund_amt) != exp_amt) begin
                        n_fail++;
                        $display("FAIL refund_amt: got %0d, expected %0d", refund_amt, exp_amt);
                    end
                end
            end
            if (coin_reject) rej_cnt++;
        end
    end

    initial begin
        int rej0;
        vecs[0] = '{2'b00, 1};
        vecs[1] = '{2'b01, 2};
        vecs[2] = '{2'b10, 5};
        vecs[3] = '{2'b11, 10};

        // Reset with the sensor held high
        rst      = 1'b1;
        coin_raw = 1'b1;
        cycle(3);
        check("rst_coin_in", coin_in, 0);
        check("rst_double_wash", double_wash, 0);
        check("rst_credit", credit, 0);
        check("rst_refund_valid", refund_valid, 0);
        check("rst_refund_amt", refund_amt, 0);
        check("rst_coin_reject", coin_reject, 0);
        rst      = 1'b0;
        coin_raw = 1'b0;
        cycle(10);
        check("post_rst_credit", credit, 0);

        // Denomination table: one coin from IDLE, then cancel refunds it
        wash_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            insert_coin(vecs[i].code);
            check($sformatf("table%0d_credit", i), credit, vecs[i].exp_credit);
            sb.push_back(vecs[i].exp_credit);
            pulse_cancel();
            wait_sb($sformatf("table%0d", i), 10);
            check($sformatf("table%0d_credit_cleared", i), credit, 0);
        end

        // Bouncy sensor produces a single event
        coin_value = 2'b11;
        for (int i = 0; i < 6; i++) begin
            coin_raw = (i % 2 == 0);
            cycle(1);
        end
        coin_raw = 1'b1;
        cycle(4);
        coin_raw = 1'b0;
        cycle(6);
        check("bounce_credit", credit, 10);
        sb.push_back(10);
        pulse_cancel();
        wait_sb("bounce", 10);

        // 5 + 5 single wash arms with no change
        double_wash_req = 1'b0;
        wash_done       = 1'b1;
        insert_coin(2'b10);
        check("single_first_credit", credit, 5);
        insert_coin(2'b10);
        check("single_coin_in", coin_in, 1);
        check("single_credit_zero", credit, 0);
        wash_done = 1'b0;
        @(negedge clk);
        check("single_coin_in_held", coin_in, 1);
        @(negedge clk);
        check("single_coin_in_dropped", coin_in, 0);
        cycle(1);

        // Coin in BUSY is diverted
        rej0 = rej_cnt;
        insert_coin(2'b01);
        check("busy_reject_pulses", rej_cnt - rej0, 1);
        check("busy_credit", credit, 0);
        wash_done = 1'b1;
        cycle(2);
        check("busy_done_coin_in", coin_in, 0);

        // 10 + 10 double wash returns 5 change
        double_wash_req = 1'b1;
        insert_coin(2'b11);
        check("double_first_credit", credit, 10);
        sb.push_back(5);
        insert_coin(2'b11);
        check("double_wash_latched", double_wash, 1);
        check("double_coin_in", coin_in, 1);
        double_wash_req = 1'b0;
        wash_done       = 1'b0;
        cycle(5);
        check("double_wash_in_busy", double_wash, 1);
        wash_done = 1'b1;
        cycle(2);
        check("double_wash_cleared", double_wash, 0);
        wait_sb("double_change", 5);

        // Cancel on the same cycle as a 5-unit coin event
        wash_done = 1'b0;
        insert_coin(2'b01);
        check("cancel_pre_credit", credit, 2);
        sb.push_back(7);
        coin_value = 2'b10;
        coin_raw   = 1'b1;
        cycle(4);
        pulse_cancel();
        coin_raw = 1'b0;
        cycle(6);
        wait_sb("cancel_same_cycle", 10);
        check("cancel_credit_cleared", credit, 0);
        insert_coin(2'b00);
        check("cancel_back_in_idle", credit, 1);
        sb.push_back(1);
        pulse_cancel();
        wait_sb("cancel_followup", 10);

        // Collect idle timeout refunds the full credit
        insert_coin(2'b00);
        check("timeout_credit", credit, 1);
        sb.push_back(1);
        cycle(200);
        check("timeout_not_early", sb.size(), 1);
        wait_sb("collect_timeout", 100);
        check("timeout_credit_cleared", credit, 0);

        // Armed without the controller starting refunds the price
        wash_done = 1'b1;
        sb.push_back(10);
        insert_coin(2'b11);
        check("armed_coin_in", coin_in, 1);
        wait_sb("accept_timeout", 40);
        cycle(1);
        check("accept_timeout_coin_in", coin_in, 0);

        // Credit saturates instead of wrapping
        wash_done = 1'b0;
        for (int i = 0; i < 26; i++) insert_coin(2'b11);
        check("saturated_credit", credit, 255);
        sb.push_back(255);
        pulse_cancel();
        wait_sb("saturated_refund", 10);

        cycle(5);
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
